etapa5_restaura: RTL and testbench

Restore-and-shift stage of the pipelined restoring divider, directly downstream of the trial-subtract stage. Consumes the trial difference in the upper half of the dividend and decides the quotient bit. On a negative difference it adds the divisor back, then shifts dividend and quotient left one place. Unlike the earlier go-only stages it supports downstream backpressure through a valid/ready handshake and a skid buffer.

---
 rtl/div_pkg.sv | 19 +
 rtl/restaura_desplaza.sv | 41 ++++
 rtl/etapa5_restaura.sv | 169 ++++++++++++++++
 tb/tb_etapa5_restaura.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the pipelined restoring divider.
// Width constants:
//   DvLen   - divisor MSB index (divisor is DvLen+1 bits)
//   DdLen   - dividend MSB index
//   QLen    - quotient MSB index
//   HiDdMin - LSB index of the dividend upper half (trial difference)
// Buffer occupancy encoding used by the valid/ready output stages.
package div_pkg;
  localparam int DvLen   = 15;
  localparam int DdLen   = 31;
  localparam int QLen    = 15;
  localparam int HiDdMin = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;
endpackage

// File: rtl/restaura_desplaza.sv
// Combinational restore-and-shift step of the restoring divider.
// Ports:
//   divisor_i   - divisor magnitude
//   dividend_i  - partial remainder, upper half holds the trial difference
//   quotient_i  - partial quotient
//   qbit_o      - new quotient bit (1 when the trial difference is >= 0)
//   dividend_o  - restored remainder shifted left one place
//   quotient_o  - partial quotient shifted left with qbit appended
module restaura_desplaza
  import div_pkg::*;
#(
  parameter int AnchoDv = DvLen,
  parameter int AnchoDd = DdLen,
  parameter int AnchoQ  = QLen,
  parameter int SupDvMn = HiDdMin
) (
  input  logic [AnchoDv:0] divisor_i,
  input  logic [AnchoDd:0] dividend_i,
  input  logic [AnchoQ:0]  quotient_i,
  output logic             qbit_o,
  output logic [AnchoDd:0] dividend_o,
  output logic [AnchoQ:0]  quotient_o
);
  logic signed [AnchoDv:0] diff;
  logic        [AnchoDv:0] rest;
  logic                    unused_qmsb;

  assign diff   = dividend_i[AnchoDd:SupDvMn];
  // Divisor < 2^AnchoDv upstream, so the top bit of diff is a true sign.
  assign qbit_o = ~diff[AnchoDv];
  // Add-back wraps modulo 2^(AnchoDv+1), which cancels the failed subtract.
  assign rest   = qbit_o ? diff : (diff + divisor_i);

  // The MSB of rest falls off the top; the lower half's MSB carries into
  // the upper half.
  assign dividend_o = {rest[AnchoDv-1:0], dividend_i[SupDvMn-1:0], 1'b0};
  assign quotient_o = {quotient_i[AnchoQ-1:0], qbit_o};

  // The quotient MSB shifts out and is not needed here.
  assign unused_qmsb = quotient_i[AnchoQ];
endmodule

// File: rtl/etapa5_restaura.sv
// Restore-and-shift stage of the pipelined restoring divider with a
// valid/ready output handshake.
// Build option: ETAPA5_SKID_EN
//   defined   - two-entry (main + skid) buffer, readyOut registered
//   undefined - single register, readyOut = ~goOut | readyIn
// Ports:
//   clk, reset (sync, active-low)
//   goIn / readyOut            - upstream handshake
//   goOut / readyIn            - downstream handshake
//   divisorIn, dividendIn, quotientIn, flag inputs  - incoming item
//   divisorOut, dividendOut, quotientOut, flag outputs - oldest held item
module etapa5_restaura
  import div_pkg::*;
#(
  parameter int AnchoDv = DvLen,
  parameter int AnchoDd = DdLen,
  parameter int AnchoQ  = QLen,
  parameter int SupDvMn = HiDdMin
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             goIn,
  output logic             readyOut,
  input  logic [AnchoDv:0] divisorIn,
  input  logic [AnchoDd:0] dividendIn,
  input  logic [AnchoQ:0]  quotientIn,
  input  logic             negDivisorIn,
  input  logic             negDividendIn,
  input  logic             DivisorNoCeroIn,
  output logic             goOut,
  input  logic             readyIn,
  output logic [AnchoDv:0] divisorOut,
  output logic [AnchoDd:0] dividendOut,
  output logic [AnchoQ:0]  quotientOut,
  output logic             negDivisorOut,
  output logic             negDividendOut,
  output logic             DivisorNoCeroOut
);
  logic [AnchoDd:0] dd_next;
  logic [AnchoQ:0]  q_next;
  logic             qbit;
  logic [2:0]       fl_in;

  buf_state_e       state_q, state_d;
  logic [AnchoDv:0] dv_q;
  logic [AnchoDd:0] dd_q;
  logic [AnchoQ:0]  q_q;
  logic [2:0]       fl_q;
  logic             xfer_in, xfer_out, ld_main_new;
`ifdef ETAPA5_SKID_EN
  logic             ready_q, ld_skid, ld_main_skid;
  logic [AnchoDv:0] sdv_q;
  logic [AnchoDd:0] sdd_q;
  logic [AnchoQ:0]  sq_q;
  logic [2:0]       sfl_q;
`endif

  // ---- combinational restore/shift ahead of the buffer ----
  restaura_desplaza #(
    .AnchoDv(AnchoDv), .AnchoDd(AnchoDd), .AnchoQ(AnchoQ), .SupDvMn(SupDvMn)
  ) u_rd (
    .divisor_i (divisorIn),
    .dividend_i(dividendIn),
    .quotient_i(quotientIn),
    .qbit_o    (qbit),
    .dividend_o(dd_next),
    .quotient_o(q_next)
  );

  assign fl_in    = {negDivisorIn, negDividendIn, DivisorNoCeroIn};
  assign goOut    = (state_q != ST_EMPTY);
`ifdef ETAPA5_SKID_EN
  assign readyOut = ready_q;
`else
  assign readyOut = ~goOut | readyIn;
`endif
  assign xfer_in  = goIn & readyOut;
  assign xfer_out = goOut & readyIn;

  always_comb begin
    state_d     = state_q;
    ld_main_new = 1'b0;
`ifdef ETAPA5_SKID_EN
    ld_skid      = 1'b0;
    ld_main_skid = 1'b0;
    case (state_q)
      ST_EMPTY: if (xfer_in) begin
        ld_main_new = 1'b1;
        state_d     = ST_ONE;
      end
      ST_ONE: begin
        if (xfer_in && xfer_out) begin
          ld_main_new = 1'b1;
        end else if (xfer_in) begin
          // Main is stalled; park the new item behind it.
          ld_skid = 1'b1;
          state_d = ST_TWO;
        end else if (xfer_out) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: if (xfer_out) begin
        ld_main_skid = 1'b1;
        state_d      = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
`else
    if (xfer_in) begin
      ld_main_new = 1'b1;
      state_d     = ST_ONE;
    end else if (xfer_out) begin
      state_d = ST_EMPTY;
    end
`endif
  end

  // ---- output register stage ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      dv_q    <= '0;
      dd_q    <= '0;
      q_q     <= '0;
      fl_q    <= '0;
`ifdef ETAPA5_SKID_EN
      ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
`ifdef ETAPA5_SKID_EN
      ready_q <= (state_d != ST_TWO);
`endif
      if (ld_main_new) begin
        dv_q <= divisorIn;
        dd_q <= dd_next;
        q_q  <= q_next;
        fl_q <= fl_in;
      end
`ifdef ETAPA5_SKID_EN
      else if (ld_main_skid) begin
        dv_q <= sdv_q;
        dd_q <= sdd_q;
        q_q  <= sq_q;
        fl_q <= sfl_q;
      end
`endif
    end
  end

`ifdef ETAPA5_SKID_EN
  // Skid contents are only read after being loaded, so no reset is needed.
  always_ff @(posedge clk) begin
    if (ld_skid) begin
      sdv_q <= divisorIn;
      sdd_q <= dd_next;
      sq_q  <= q_next;
      sfl_q <= fl_in;
    end
  end
`endif

  assign divisorOut       = dv_q;
  assign dividendOut      = dd_q;
  assign quotientOut      = q_q;
  assign negDivisorOut    = fl_q[2];
  assign negDividendOut   = fl_q[1];
  assign DivisorNoCeroOut = fl_q[0];
endmodule

// File: tb/tb_etapa5_restaura.sv
module tb_etapa5_restaura;
`ifdef ETAPA5_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] dv;
    logic [31:0] dd;
    logic [15:0] q;
    logic [2:0]  fl;   // {negDivisor, negDividend, DivisorNoCero}
  } item_t;

  typedef struct {
    item_t       in;
    logic [31:0] edd;
    logic [15:0] eq;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        goIn = 1'b0, readyIn = 1'b0;
  logic        readyOut, goOut;
  logic [15:0] divisorIn = '0, divisorOut;
  logic [31:0] dividendIn = '0, dividendOut;
  logic [15:0] quotientIn = '0, quotientOut;
  logic        negDivisorIn = 1'b0, negDividendIn = 1'b0, DivisorNoCeroIn = 1'b0;
  logic        negDivisorOut, negDividendOut, DivisorNoCeroOut;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  etapa5_restaura dut (
    .clk(clk), .reset(reset), .goIn(goIn), .readyOut(readyOut),
    .divisorIn(divisorIn), .dividendIn(dividendIn), .quotientIn(quotientIn),
    .negDivisorIn(negDivisorIn), .negDividendIn(negDividendIn),
    .DivisorNoCeroIn(DivisorNoCeroIn), .goOut(goOut), .readyIn(readyIn),
    .divisorOut(divisorOut), .dividendOut(dividendOut), .quotientOut(quotientOut),
    .negDivisorOut(negDivisorOut), .negDividendOut(negDividendOut),
    .DivisorNoCeroOut(DivisorNoCeroOut)
  );

  function automatic item_t outs();
    return {divisorOut, dividendOut, quotientOut,
            negDivisorOut, negDividendOut, DivisorNoCeroOut};
  endfunction

  // Reference: restoring-division step done with plain integer arithmetic.
  function automatic item_t model(input item_t x);
    longint unsigned d, lo, r;
    bit qb;
    item_t y;
    d  = x.dd / 65536;
    lo = x.dd % 65536;
    qb = (d < 32768);
    r  = qb ? d : (d + x.dv) % 65536;
    y.dv = x.dv;
    y.fl = x.fl;
    y.dd = 32'(((r * 65536) + lo) * 2 % 64'h1_0000_0000);
    y.q  = 16'(((longint'(x.q) * 2) + qb) % 65536);
    return y;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input item_t x, input bit go, input bit rdy);
    divisorIn = x.dv; dividendIn = x.dd; quotientIn = x.q;
    {negDivisorIn, negDividendIn, DivisorNoCeroIn} = x.fl;
    goIn = go; readyIn = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic item_t rnd_item();
    item_t x;
    x.dv = 16'($urandom_range(0, 32767));
    x.dd = 32'($urandom);
    x.q  = 16'($urandom);
    x.fl = 3'($urandom);
    return x;
  endfunction

  vec_t  tbl[6];
  item_t a, b, z, exp_it;
  item_t sb[$];
  item_t stream[16];
  bit    exp_go, exp_rdy, xin, xout;

  initial begin
    z = '0;
    tbl[0] = '{'{16'h0007, 32'h005D0000, 16'h0000, 3'b000}, 32'h00BA0000, 16'h0001};
    tbl[1] = '{'{16'h0007, 32'hFFFC8000, 16'h0000, 3'b000}, 32'h00070000, 16'h0000};
    tbl[2] = '{'{16'h1234, 32'h00010001, 16'h8001, 3'b100}, 32'h00020002, 16'h0003};
    tbl[3] = '{'{16'h7FFF, 32'h8000FFFF, 16'h7FFF, 3'b011}, 32'hFFFFFFFE, 16'hFFFE};
    tbl[4] = '{'{16'h0000, 32'hFFFF0000, 16'h5555, 3'b111}, 32'hFFFE0000, 16'hAAAA};
    tbl[5] = '{'{16'h0003, 32'h7FFF8000, 16'h0000, 3'b001}, 32'hFFFF0000, 16'h0001};

    // Reset state
    drive(z, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_go", goOut, 1'b0);
    chk("rst_data", outs(), '0);
    reset = 1'b1;
    tick();
    chk("rst_ready", readyOut, 1'b1);
    chk("rst_go_after", goOut, 1'b0);

    // Directed vectors, one item each through an empty stage
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].in, 1'b1, 1'b1);
      tick();
      goIn = 1'b0;
      exp_it = tbl[i].in;
      exp_it.dd = tbl[i].edd;
      exp_it.q  = tbl[i].eq;
      chk($sformatf("vec%0d_go", i), goOut, 1'b1);
      chk($sformatf("vec%0d_out", i), outs(), exp_it);
      tick();
      chk($sformatf("vec%0d_drain", i), goOut, 1'b0);
    end

    // Backpressure
    a = rnd_item(); b = rnd_item();
`ifdef ETAPA5_SKID_EN
    drive(a, 1'b1, 1'b0); tick();
    chk("bp_ready_one", readyOut, 1'b1);
    drive(b, 1'b1, 1'b0); tick();
    goIn = 1'b0;
    chk("bp_ready_two", readyOut, 1'b0);
    chk("bp_go", goOut, 1'b1);
    chk("bp_A", outs(), model(a));
    tick();
    chk("bp_A_hold", outs(), model(a));
    chk("bp_ready_hold", readyOut, 1'b0);
    readyIn = 1'b1; tick();
    chk("bp_B", outs(), model(b));
    chk("bp_B_go", goOut, 1'b1);
    chk("bp_ready_back", readyOut, 1'b1);
    tick();
    chk("bp_empty", goOut, 1'b0);
`else
    drive(a, 1'b1, 1'b0); tick();
    drive(b, 1'b1, 1'b0);
    chk("bp_ready_full", readyOut, 1'b0);
    chk("bp_go", goOut, 1'b1);
    chk("bp_A", outs(), model(a));
    tick();
    chk("bp_A_hold", outs(), model(a));
    goIn = 1'b0; readyIn = 1'b1; #1;
    chk("bp_ready_comb", readyOut, 1'b1);
    tick();
    chk("bp_empty", goOut, 1'b0);
`endif

    // Streaming: 16 back-to-back items
    for (int i = 0; i < 16; i++) stream[i] = rnd_item();
    for (int i = 0; i < 16; i++) begin
      drive(stream[i], 1'b1, 1'b1);
      tick();
      chk($sformatf("stream%0d_go", i), goOut, 1'b1);
      chk($sformatf("stream%0d_out", i), outs(), model(stream[i]));
      chk($sformatf("stream%0d_rdy", i), readyOut, 1'b1);
    end
    goIn = 1'b0; tick();
    chk("stream_end", goOut, 1'b0);

    // Reset while stalled (full buffer)
    drive(rnd_item(), 1'b1, 1'b0); tick();
    drive(rnd_item(), 1'b1, 1'b0); tick();
    goIn = 1'b0;
    reset = 1'b0; tick();
    chk("rst2_go", goOut, 1'b0);
    chk("rst2_data", outs(), '0);
    reset = 1'b1; tick();
    chk("rst2_ready", readyOut, 1'b1);
    readyIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst2_no_stale", goOut, 1'b0);
    end

    // Randomized traffic against an occupancy/order scoreboard
    sb.delete();
    for (int c = 0; c < 600; c++) begin
      drive(rnd_item(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6));
      @(negedge clk);
      exp_go  = (sb.size() > 0);
      exp_rdy = SKID ? (sb.size() < 2) : (sb.size() == 0 || readyIn);
      chk("rnd_go", goOut, exp_go);
      chk("rnd_ready", readyOut, exp_rdy);
      if (exp_go) chk("rnd_data", outs(), sb[0]);
      xin  = goIn && exp_rdy;
      xout = exp_go && readyIn;
      exp_it = model({divisorIn, dividendIn, quotientIn,
                      negDivisorIn, negDividendIn, DivisorNoCeroIn});
      @(posedge clk);
      if (xout && sb.size() > 0) void'(sb.pop_front());
      if (xin) sb.push_back(exp_it);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
